// File: rtl/branch_recovery_ctrl.sv
// Branch mispredict recovery sequencer.
// Takes the checkpoint lookup on a mispredict, then walks FLUSH -> CLEAR -> REDIRECT.
// CLEAR streams the snapshot ready-table to the ready-table one chunk per cycle.
// Rename is held off (busy) for the whole walk.

package types_pkg;
  parameter int PR_COUNT = 128;
  parameter int TAG_W    = 5;

  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [TAG_W-1:0]    rob_tag;
    logic [PR_COUNT-1:0] reset_reg_rdy_table;
  } checkpoint;
endpackage

module branch_recovery_ctrl #(
  parameter int PR_COUNT = types_pkg::PR_COUNT,
  parameter int CLR_W    = 16,
  parameter int TAG_W    = types_pkg::TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mispredict,
  input  logic [TAG_W-1:0]            mispredict_tag,
  input  logic [31:0]                 resolved_target,
  input  logic                        checkpoint_valid,
  input  types_pkg::checkpoint        snapshot,
  output logic                        flush,
  output logic                        flush_all,
  output logic [TAG_W-1:0]            flush_tag,
  output logic                        rdy_clr_valid,
  output logic [$clog2(PR_COUNT)-1:0] rdy_clr_base,
  output logic [CLR_W-1:0]            rdy_clr_mask,
  output logic                        redirect_valid,
  output logic [31:0]                 redirect_pc,
  input  logic                        redirect_ready,
  output logic                        busy,
  output logic                        recover_done,
  output logic                        overrun
);

  localparam int NCHUNK  = PR_COUNT / CLR_W;
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BASE_W  = $clog2(PR_COUNT);
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_CLEAR    = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]          state_reg, state_next;
  logic [CHUNK_W-1:0]  chunk_reg, chunk_next;
  logic [TAG_W-1:0]    tag_reg;
  logic [31:0]         target_reg;
  logic                ckpt_valid_reg;
  logic [PR_COUNT-1:0] table_reg;
  logic                overrun_reg;

  // The snapshot PC is not needed: the redirect uses the resolved target.
  logic unused_snapshot_pc;
  assign unused_snapshot_pc = ^snapshot.pc;

  // A snapshot only counts when the store hit, the entry is valid and it belongs to this branch.
  logic ckpt_usable;
  assign ckpt_usable = checkpoint_valid && snapshot.valid && (snapshot.rob_tag == mispredict_tag);

  // Slice the latched ready table into CLEAR-sized chunks.
  logic [CLR_W-1:0] chunk_arr [NCHUNK];
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign chunk_arr[gi] = table_reg[gi*CLR_W +: CLR_W];
    end
  endgenerate

  // Next-state and chunk-counter sequencing.
  always_comb begin
    state_next = state_reg;
    chunk_next = chunk_reg;
    case (state_reg)
      S_IDLE: begin
        chunk_next = '0;
        if (mispredict) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        chunk_next = '0;
        state_next = ckpt_valid_reg ? S_CLEAR : S_REDIRECT;
      end
      S_CLEAR: begin
        if (chunk_reg == LAST_CHUNK) begin
          chunk_next = '0;
          state_next = S_REDIRECT;
        end else begin
          chunk_next = chunk_reg + 1'b1;
        end
      end
      default: begin
        if (redirect_ready) state_next = S_IDLE;
      end
    endcase
  end

  // State, counter, mispredict context capture and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      chunk_reg      <= '0;
      tag_reg        <= '0;
      target_reg     <= '0;
      ckpt_valid_reg <= 1'b0;
      table_reg      <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      chunk_reg <= chunk_next;
      if (mispredict && (state_reg == S_IDLE)) begin
        tag_reg        <= mispredict_tag;
        target_reg     <= resolved_target;
        ckpt_valid_reg <= ckpt_usable;
        table_reg      <= snapshot.reset_reg_rdy_table;
      end
      if (mispredict && (state_reg != S_IDLE)) overrun_reg <= 1'b1;
    end
  end

  // Output decode from registered state; fields are zeroed outside their own state.
  logic in_clear;
  assign in_clear       = (state_reg == S_CLEAR);
  assign busy           = (state_reg != S_IDLE);
  assign flush          = (state_reg == S_FLUSH);
  assign flush_all      = flush && !ckpt_valid_reg;
  assign flush_tag      = flush ? tag_reg : '0;
  assign rdy_clr_mask   = in_clear ? chunk_arr[chunk_reg] : '0;
  assign rdy_clr_valid  = |rdy_clr_mask;
  assign rdy_clr_base   = in_clear ? BASE_W'(int'(chunk_reg) * CLR_W) : '0;
  assign redirect_valid = (state_reg == S_REDIRECT);
  assign redirect_pc    = redirect_valid ? target_reg : '0;
  // Completion is reported in the handshake cycle itself, so it follows redirect_ready.
  assign recover_done   = redirect_valid && redirect_ready;
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl: vector table for the basic recovery,
// hand-written sequences for stall, overrun, mid-sequence reset and empty table.
module tb_branch_recovery_ctrl;

  typedef struct packed {
    logic        flush;
    logic        flush_all;
    logic [4:0]  ftag;
    logic        clr_v;
    logic [6:0]  base;
    logic [15:0] mask;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
    logic        done;
    logic        ovr;
  } out_t;

  typedef struct {
    logic       mp;
    logic [4:0] tag;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mispredict;
  logic [4:0]           mispredict_tag;
  logic [31:0]          resolved_target;
  logic                 checkpoint_valid;
  types_pkg::checkpoint snapshot;
  logic                 flush, flush_all;
  logic [4:0]           flush_tag;
  logic                 rdy_clr_valid;
  logic [6:0]           rdy_clr_base;
  logic [15:0]          rdy_clr_mask;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 redirect_ready;
  logic                 busy, recover_done, overrun;

  int n_checks = 0;
  int n_errors = 0;

  vec_t t1_vec [12];
  logic [15:0] t1_mask [8];

  always #5 clk = ~clk;

  branch_recovery_ctrl #(.PR_COUNT(128), .CLR_W(16), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .resolved_target(resolved_target), .checkpoint_valid(checkpoint_valid), .snapshot(snapshot),
    .flush(flush), .flush_all(flush_all), .flush_tag(flush_tag), .rdy_clr_valid(rdy_clr_valid),
    .rdy_clr_base(rdy_clr_base), .rdy_clr_mask(rdy_clr_mask), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .busy(busy),
    .recover_done(recover_done), .overrun(overrun)
  );

  function automatic out_t o_idle(logic ovr);
    out_t o = '0;
    o.ovr = ovr;
    return o;
  endfunction

  function automatic out_t o_flush(logic [4:0] tag, logic all, logic ovr);
    out_t o = '0;
    o.flush = 1'b1; o.flush_all = all; o.ftag = tag; o.busy = 1'b1; o.ovr = ovr;
    return o;
  endfunction

  function automatic out_t o_clear(int c, logic [15:0] mask, logic ovr);
    out_t o = '0;
    o.base = 7'(c * 16); o.mask = mask; o.clr_v = (mask != 16'h0); o.busy = 1'b1; o.ovr = ovr;
    return o;
  endfunction

  function automatic out_t o_redir(logic [31:0] pc, logic done, logic ovr);
    out_t o = '0;
    o.rv = 1'b1; o.rpc = pc; o.busy = 1'b1; o.done = done; o.ovr = ovr;
    return o;
  endfunction

  function automatic vec_t mk(logic mp, logic [4:0] tag, logic rdy, out_t exp);
    vec_t v;
    v.mp = mp; v.tag = tag; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle of inputs, compare outputs of the current cycle, advance one clock.
  task automatic apply(input string name, input logic mp, input logic [4:0] tag,
                       input logic rdy, input out_t exp);
    out_t act;
    mispredict     = mp;
    mispredict_tag = tag;
    redirect_ready = rdy;
    #1;
    act = '{flush, flush_all, flush_tag, rdy_clr_valid, rdy_clr_base, rdy_clr_mask,
            redirect_valid, redirect_pc, busy, recover_done, overrun};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_snap(input logic sv, input logic [4:0] stag, input logic [127:0] tbl,
                          input logic cv, input logic [31:0] target);
    snapshot.valid               = sv;
    snapshot.pc                  = 32'hdead_0000;
    snapshot.rob_tag             = stag;
    snapshot.reset_reg_rdy_table = tbl;
    checkpoint_valid             = cv;
    resolved_target              = target;
  endtask

  task automatic set_t1_snap();
    logic [127:0] tbl;
    tbl = '0;
    tbl[3] = 1'b1; tbl[20] = 1'b1; tbl[127] = 1'b1;
    set_snap(1'b1, 5'd5, tbl, 1'b1, 32'h100);
  endtask

  task automatic run_t1(input string name);
    for (int i = 0; i < 12; i++)
      apply($sformatf("%s_row%0d", name, i), t1_vec[i].mp, t1_vec[i].tag, t1_vec[i].rdy, t1_vec[i].exp);
    $display("%s: mispredict tag 5 recovered, 3 chunks cleared, redirect 0x100", name);
  endtask

  initial begin
    // Expected sequence for tag 5, table bits {3,20,127}, target 0x100, ready high.
    t1_mask = '{16'h0008, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000};
    t1_vec[0] = mk(1'b1, 5'd5, 1'b1, o_idle(1'b0));
    t1_vec[1] = mk(1'b0, 5'd0, 1'b1, o_flush(5'd5, 1'b0, 1'b0));
    for (int c = 0; c < 8; c++)
      t1_vec[2+c] = mk(1'b0, 5'd0, 1'b1, o_clear(c, t1_mask[c], 1'b0));
    t1_vec[10] = mk(1'b0, 5'd0, 1'b1, o_redir(32'h100, 1'b1, 1'b0));
    t1_vec[11] = mk(1'b0, 5'd0, 1'b1, o_idle(1'b0));

    reset = 1'b1; mispredict = 1'b0; mispredict_tag = '0; redirect_ready = 1'b0;
    set_snap(1'b0, 5'd0, '0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    apply("reset_hold", 1'b1, 5'd1, 1'b1, o_idle(1'b0));
    reset = 1'b0;
    apply("reset_state", 1'b0, 5'd0, 1'b1, o_idle(1'b0));

    // T1: basic recovery with a valid checkpoint.
    set_t1_snap();
    run_t1("T1");

    // T2: no checkpoint -> flush_all, straight to redirect.
    set_snap(1'b1, 5'd9, '1, 1'b0, 32'h200);
    apply("T2_accept", 1'b1, 5'd9, 1'b1, o_idle(1'b0));
    apply("T2_flush", 1'b0, 5'd0, 1'b1, o_flush(5'd9, 1'b1, 1'b0));
    apply("T2_redir", 1'b0, 5'd0, 1'b1, o_redir(32'h200, 1'b1, 1'b0));
    apply("T2_idle", 1'b0, 5'd0, 1'b1, o_idle(1'b0));
    $display("T2: no-checkpoint mispredict tag 9 flushed all, redirect 0x200");

    // T2b: checkpoint hit but for a different branch -> also flush_all.
    set_snap(1'b1, 5'd6, '1, 1'b1, 32'h300);
    apply("T2b_accept", 1'b1, 5'd7, 1'b1, o_idle(1'b0));
    apply("T2b_flush", 1'b0, 5'd0, 1'b1, o_flush(5'd7, 1'b1, 1'b0));
    apply("T2b_redir", 1'b0, 5'd0, 1'b1, o_redir(32'h300, 1'b1, 1'b0));
    $display("T2b: tag-mismatched snapshot tag 7 flushed all, redirect 0x300");

    // T3: fetch holds off the redirect for 5 cycles.
    set_t1_snap();
    for (int i = 0; i < 10; i++)
      apply($sformatf("T3_row%0d", i), t1_vec[i].mp, t1_vec[i].tag, 1'b0, t1_vec[i].exp);
    for (int i = 0; i < 5; i++)
      apply($sformatf("T3_stall%0d", i), 1'b0, 5'd0, 1'b0, o_redir(32'h100, 1'b0, 1'b0));
    apply("T3_handshake", 1'b0, 5'd0, 1'b1, o_redir(32'h100, 1'b1, 1'b0));
    apply("T3_idle", 1'b0, 5'd0, 1'b1, o_idle(1'b0));
    $display("T3: redirect held 5 stall cycles then accepted");

    // T4: second mispredict during CLEAR is dropped and raises overrun.
    set_t1_snap();
    for (int i = 0; i < 12; i++) begin
      logic mp;
      logic [4:0] tag;
      out_t e;
      mp = t1_vec[i].mp; tag = t1_vec[i].tag; e = t1_vec[i].exp;
      if (i == 4) begin mp = 1'b1; tag = 5'd12; end
      if (i >= 5) e.ovr = 1'b1;
      apply($sformatf("T4_row%0d", i), mp, tag, 1'b1, e);
    end
    for (int i = 0; i < 3; i++)
      apply($sformatf("T4_sticky%0d", i), 1'b0, 5'd0, 1'b1, o_idle(1'b1));
    $display("T4: mispredict tag 12 dropped during CLEAR, overrun sticky");

    // T5: reset in the middle of CLEAR, then a fresh full recovery.
    for (int i = 0; i < 4; i++) begin
      out_t e;
      e = t1_vec[i].exp; e.ovr = 1'b1;
      apply($sformatf("T5_row%0d", i), t1_vec[i].mp, t1_vec[i].tag, 1'b1, e);
    end
    reset = 1'b1;
    apply("T5_reset_cycle", 1'b0, 5'd0, 1'b1, o_clear(2, 16'h0, 1'b1));
    reset = 1'b0;
    apply("T5_after_reset", 1'b0, 5'd0, 1'b1, o_idle(1'b0));
    run_t1("T5_rerun");

    // T6: empty ready table, plus a mispredict landing on the handshake cycle.
    set_snap(1'b1, 5'd3, '0, 1'b1, 32'h400);
    apply("T6_accept", 1'b1, 5'd3, 1'b1, o_idle(1'b0));
    apply("T6_flush", 1'b0, 5'd0, 1'b1, o_flush(5'd3, 1'b0, 1'b0));
    for (int c = 0; c < 8; c++)
      apply($sformatf("T6_clear%0d", c), 1'b0, 5'd0, 1'b1, o_clear(c, 16'h0, 1'b0));
    apply("T6_redir_mp", 1'b1, 5'd4, 1'b1, o_redir(32'h400, 1'b1, 1'b0));
    apply("T6_dropped", 1'b0, 5'd0, 1'b1, o_idle(1'b1));
    apply("T6_still_idle", 1'b0, 5'd0, 1'b1, o_idle(1'b1));
    $display("T6: empty table recovered, handshake-cycle mispredict tag 4 dropped");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
